// File: rtl/uart_rx_os_if.sv
// Received-word handshake bundle for uart_rx_os.
// master = receiver side, slave = consumer side.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with sticky error flags and valid/ready output.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting per bit.
module uart_rx_os #(
  parameter int CLK_DIV     = 10,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int LSB_FIRST   = 1
) (
  input  logic         clk_24,
  input  logic         reset,
  input  logic         rx,
  uart_rx_os_if.master bus,
  input  logic         err_clr,
  output logic         frame_err,
  output logic         parity_err,
  output logic         overrun,
  output logic         busy
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int DV_W = $clog2(CLK_DIV);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = OVERSAMPLE / 2;
`else
  localparam int START_PT = OVERSAMPLE / 2 - 1;
`endif
  localparam logic PAR_ODD = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t r_state, w_state_n;

  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]           r_fill;
  logic [DV_W-1:0]      r_div;
  logic [OS_W-1:0]      r_os_cnt;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_par_pend;
  logic                 r_frame_err, r_parity_err, r_overrun;

  logic w_tick, w_fall, w_dec, w_bit;
  logic w_done, w_accept, w_load;
  logic w_fe_set, w_pe_set, w_ov_set;

  // r_fill keeps reset-time sync values from looking like a falling edge
  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_fill    <= 2'd0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  assign w_fall = (r_fill == 2'd3) & r_rx_prev & ~r_rx_sync;
  assign w_tick = (r_div == DV_W'(CLK_DIV - 1));
  assign w_dec  = w_tick & (r_os_cnt == ((r_state == S_START) ?
                  OS_W'(START_PT) : OS_W'(OVERSAMPLE - 1)));

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset)       r_hist <= 2'b11;
    else if (w_tick) r_hist <= {r_hist[0], r_rx_sync};
  end

  assign w_bit = (r_hist[1] & r_hist[0]) |
                 (r_hist[1] & r_rx_sync) |
                 (r_hist[0] & r_rx_sync);
`else
  assign w_bit = r_rx_sync;
`endif

  assign w_done   = (r_state == S_STOP) & w_dec &
                    (r_bit_idx == 4'(STOP_BITS - 1));
  assign w_accept = r_valid & bus.data_ready;
  assign w_load   = w_done & (~r_valid | w_accept);
  assign w_fe_set = (r_state == S_STOP) & w_dec & ~w_bit;
  assign w_pe_set = w_load & r_par_pend;
  assign w_ov_set = w_done & r_valid & ~w_accept;

  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_state_n = S_START;
      S_START:  if (w_dec) w_state_n = w_bit ? S_IDLE : S_DATA;
      S_DATA:
        if (w_dec && r_bit_idx == 4'(DATA_BITS - 1))
          w_state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_dec) w_state_n = S_STOP;
      S_STOP:   if (w_done) w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) begin
      r_div      <= '0;
      r_os_cnt   <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_pend <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (r_state == S_IDLE && w_fall) r_os_cnt <= '0;
      else if (w_tick) r_os_cnt <= w_dec ? '0 : r_os_cnt + 1'b1;
      if (w_dec) begin
        case (r_state)
          S_START: begin
            r_bit_idx  <= '0;
            r_par_pend <= 1'b0;
          end
          S_DATA: begin
            if (LSB_FIRST != 0)
              r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            else
              r_shift <= {r_shift[DATA_BITS-2:0], w_bit};
            r_bit_idx <= (r_bit_idx == 4'(DATA_BITS - 1)) ?
                         4'd0 : r_bit_idx + 4'd1;
          end
          S_PARITY: begin
            r_par_pend <= ((^r_shift) ^ w_bit) != PAR_ODD;
            r_bit_idx  <= '0;
          end
          S_STOP:  r_bit_idx <= r_bit_idx + 4'd1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_fe_set)     r_frame_err  <= 1'b1;
      else if (err_clr) r_frame_err  <= 1'b0;
      if (w_pe_set)     r_parity_err <= 1'b1;
      else if (err_clr) r_parity_err <= 1'b0;
      if (w_ov_set)     r_overrun    <= 1'b1;
      else if (err_clr) r_overrun    <= 1'b0;
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_valid;
  assign frame_err      = r_frame_err;
  assign parity_err     = r_parity_err;
  assign overrun        = r_overrun;
  assign busy           = (r_state != S_IDLE);
endmodule
